controller: RTL and testbench

//  Multi-cycle control FSM of a RISC-V PE. Takes decoded RV32I fields and sequences one instruction per run:

---
 rtl/controller_if.sv | 62 ++++++
 rtl/controller.sv | 265 ++++++++++++++++++++++++++
 tb/tb_controller.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/controller_if.sv
`timescale 1ns/1ps
// Signal bundle between the RV32I control FSM and its neighbours (decoder, regfile, ALU, memory).
// master = controller side, slave = datapath/test side.
interface controller_if #(
  parameter int XLEN = 32
);
  // decoded instruction fields
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [11:0]     imm12;
  logic [19:0]     immhi;
  logic [XLEN-1:0] PCin;
  logic [XLEN-1:0] ALURes;

  // completion strobes and branch outcome
  logic            dataReady;
  logic            ALUcomplete;
  logic            mem_ack;
  logic            decodeComplete;
  logic            ALU0;

  // controller outputs
  logic [XLEN-1:0] PCout;
  logic [XLEN-1:0] immvalue;
  logic [4:0]      ALUsel;
  logic [1:0]      Asel;
  logic [1:0]      Bsel;
  logic [1:0]      Osel;
  logic [4:0]      rs1Out;
  logic [4:0]      rs2Out;
  logic [4:0]      rdOut;
  logic            rdWrite;
  logic            Aenable;
  logic            Benable;
  logic            IRenable;
  logic            reg_reset;
  logic            reg_select;
  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] mem_address;
  logic            execution_complete;

  modport master (
    input  op, funct3, funct7, rs1, rs2, rd, imm12, immhi, PCin, ALURes,
    input  dataReady, ALUcomplete, mem_ack, decodeComplete, ALU0,
    output PCout, immvalue, ALUsel, Asel, Bsel, Osel, rs1Out, rs2Out, rdOut,
    output rdWrite, Aenable, Benable, IRenable, reg_reset, reg_select,
    output mem_read, mem_write, mem_address, execution_complete
  );

  modport slave (
    output op, funct3, funct7, rs1, rs2, rd, imm12, immhi, PCin, ALURes,
    output dataReady, ALUcomplete, mem_ack, decodeComplete, ALU0,
    input  PCout, immvalue, ALUsel, Asel, Bsel, Osel, rs1Out, rs2Out, rdOut,
    input  rdWrite, Aenable, Benable, IRenable, reg_reset, reg_select,
    input  mem_read, mem_write, mem_address, execution_complete
  );
endinterface

// File: rtl/controller.sv
`timescale 1ns/1ps
// Multi-cycle RV32I control FSM: decode, operand read, ALU, memory, write-back, next PC; all outputs registered.
// Optional DECODE_HANDSHAKE_EN: DECODE holds (IRenable high) until the decoder raises decodeComplete.
module controller #(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input logic          clk,
  input logic          reset,
  controller_if.master bus
);

  typedef enum logic [2:0] {
    S_DECODE,
    S_READ,
    S_EXEC,
    S_STORE_WAIT,
    S_MEM,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'd3;
  localparam logic [6:0] OPC_OPIMM  = 7'd19;
  localparam logic [6:0] OPC_STORE  = 7'd35;
  localparam logic [6:0] OPC_OP     = 7'd51;
  localparam logic [6:0] OPC_LUI    = 7'd55;
  localparam logic [6:0] OPC_BRANCH = 7'd99;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_BEQ  = 5'd11;
  localparam logic [4:0] ALU_BNE  = 5'd12;
  localparam logic [4:0] ALU_BLT  = 5'd13;
  localparam logic [4:0] ALU_BGE  = 5'd14;
  localparam logic [4:0] ALU_BLTU = 5'd15;
  localparam logic [4:0] ALU_BGEU = 5'd16;

  localparam logic [1:0] OSEL_ALU = 2'd0;
  localparam logic [1:0] OSEL_MEM = 2'd1;
  localparam logic [1:0] OSEL_IMM = 2'd3;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  state_t     state;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic       alt_q;

  logic            decode_go;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] imm_fmt;
  logic            unused_inputs;

`ifdef DECODE_HANDSHAKE_EN
  assign decode_go = bus.decodeComplete;
`else
  assign decode_go = 1'b1;
`endif

  assign unused_inputs = &{1'b0, bus.funct7[6], bus.funct7[4:0], bus.decodeComplete};

  assign imm_sext = {{(XLEN-12){bus.imm12[11]}}, bus.imm12};

  always_comb begin
    imm_fmt = '0;
    case (bus.op)
      OPC_LOAD, OPC_STORE: imm_fmt = imm_sext;
      OPC_OPIMM: begin
        // shift-immediates carry only a 5-bit shamt; the upper bits hold the SRAI selector
        if (bus.funct3 == 3'd1 || bus.funct3 == 3'd5)
          imm_fmt = {{(XLEN-5){1'b0}}, bus.imm12[4:0]};
        else
          imm_fmt = imm_sext;
      end
      OPC_LUI:    imm_fmt = XLEN'({bus.immhi, 12'h000});
      OPC_BRANCH: imm_fmt = imm_sext << 1;
      default:    imm_fmt = '0;
    endcase
  end

  function automatic logic [4:0] alu_op(input logic [6:0] opc, input logic [2:0] f3, input logic alt);
    logic [4:0] sel;
    sel = ALU_ADD;
    if (opc == OPC_OP || opc == OPC_OPIMM) begin
      case (f3)
        3'd0:    sel = (opc == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
        3'd1:    sel = ALU_SLL;
        3'd2:    sel = ALU_SLT;
        3'd3:    sel = ALU_SLTU;
        3'd4:    sel = ALU_XOR;
        3'd5:    sel = alt ? ALU_SRA : ALU_SRL;
        3'd6:    sel = ALU_OR;
        default: sel = ALU_AND;
      endcase
    end else if (opc == OPC_BRANCH) begin
      case (f3)
        3'd1:    sel = ALU_BNE;
        3'd4:    sel = ALU_BLT;
        3'd5:    sel = ALU_BGE;
        3'd6:    sel = ALU_BLTU;
        3'd7:    sel = ALU_BGEU;
        default: sel = ALU_BEQ;
      endcase
    end
    return sel;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= S_DECODE;
      op_q                   <= '0;
      f3_q                   <= '0;
      alt_q                  <= 1'b0;
      bus.PCout              <= '0;
      bus.immvalue           <= '0;
      bus.ALUsel             <= '0;
      bus.Asel               <= '0;
      bus.Bsel               <= '0;
      bus.Osel               <= '0;
      bus.rs1Out             <= '0;
      bus.rs2Out             <= '0;
      bus.rdOut              <= '0;
      bus.rdWrite            <= 1'b0;
      bus.Aenable            <= 1'b0;
      bus.Benable            <= 1'b0;
      bus.IRenable           <= 1'b0;
      bus.reg_reset          <= 1'b1;
      bus.reg_select         <= 1'b0;
      bus.mem_read           <= 1'b0;
      bus.mem_write          <= 1'b0;
      bus.mem_address        <= '0;
      bus.execution_complete <= 1'b0;
    end else begin
      // strobes are single-state outputs; each state re-asserts the ones it owns
      bus.reg_reset          <= 1'b0;
      bus.rdWrite            <= 1'b0;
      bus.reg_select         <= 1'b0;
      bus.Aenable            <= 1'b0;
      bus.Benable            <= 1'b0;
      bus.IRenable           <= 1'b0;
      bus.mem_read           <= 1'b0;
      bus.mem_write          <= 1'b0;
      bus.execution_complete <= 1'b0;

      case (state)
        S_DECODE: begin
          bus.IRenable <= 1'b1;
          if (decode_go) begin
            op_q         <= bus.op;
            f3_q         <= bus.funct3;
            alt_q        <= bus.funct7[5];
            bus.rs1Out   <= bus.rs1;
            bus.rs2Out   <= bus.rs2;
            bus.rdOut    <= bus.rd;
            bus.immvalue <= imm_fmt;
            case (bus.op)
              OPC_LUI: begin
                state          <= S_WB;
                bus.Osel       <= OSEL_IMM;
                bus.rdWrite    <= (bus.rd != 5'd0);
                bus.reg_select <= (bus.rd != 5'd0);
              end
              OPC_LOAD, OPC_OPIMM, OPC_OP, OPC_STORE, OPC_BRANCH: begin
                state       <= S_READ;
                bus.Aenable <= 1'b1;
                bus.Benable <= 1'b1;
              end
              default: begin
                state                  <= S_DONE;
                bus.PCout              <= bus.PCin + STEP;
                bus.execution_complete <= 1'b1;
              end
            endcase
          end
        end

        S_READ: begin
          if (bus.dataReady) begin
            state      <= S_EXEC;
            bus.ALUsel <= alu_op(op_q, f3_q, alt_q);
            bus.Asel   <= 2'd0;
            bus.Bsel   <= (op_q == OPC_OP || op_q == OPC_BRANCH) ? 2'd0 : 2'd1;
          end else begin
            bus.Aenable <= 1'b1;
            bus.Benable <= 1'b1;
          end
        end

        S_EXEC: begin
          if (bus.ALUcomplete) begin
            case (op_q)
              OPC_LOAD: begin
                state           <= S_MEM;
                bus.mem_address <= bus.ALURes;
                bus.mem_read    <= 1'b1;
              end
              OPC_STORE: begin
                state           <= S_STORE_WAIT;
                bus.mem_address <= bus.ALURes;
              end
              OPC_BRANCH: begin
                state                  <= S_DONE;
                bus.PCout              <= bus.ALU0 ? (bus.PCin + bus.immvalue) : (bus.PCin + STEP);
                bus.execution_complete <= 1'b1;
              end
              default: begin
                state          <= S_WB;
                bus.Osel       <= OSEL_ALU;
                bus.rdWrite    <= (bus.rdOut != 5'd0);
                bus.reg_select <= (bus.rdOut != 5'd0);
              end
            endcase
          end
        end

        S_STORE_WAIT: begin
          // rs2 data must be on the bus before the write strobe goes out
          if (bus.dataReady) begin
            state         <= S_MEM;
            bus.mem_write <= 1'b1;
          end
        end

        S_MEM: begin
          if (bus.mem_ack) begin
            if (op_q == OPC_LOAD) begin
              state          <= S_WB;
              bus.Osel       <= OSEL_MEM;
              bus.rdWrite    <= (bus.rdOut != 5'd0);
              bus.reg_select <= (bus.rdOut != 5'd0);
            end else begin
              state                  <= S_DONE;
              bus.PCout              <= bus.PCin + STEP;
              bus.execution_complete <= 1'b1;
            end
          end else begin
            bus.mem_read  <= (op_q == OPC_LOAD);
            bus.mem_write <= (op_q != OPC_LOAD);
          end
        end

        S_WB: begin
          state                  <= S_DONE;
          bus.PCout              <= bus.PCin + STEP;
          bus.execution_complete <= 1'b1;
        end

        default: begin
          state                  <= S_DONE;
          bus.execution_complete <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controller.sv
`timescale 1ns/1ps
// Bench for the RV32I control FSM: table of instructions through a scoreboard,
// plus hand sequences for stalled handshakes, store data wait and mid-operation reset.
module tb_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;

  controller_if #(.XLEN(32)) bus ();

  controller #(.XLEN(32), .PC_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] imm12;
    logic [19:0] immhi;
    logic [31:0] pcin;
    logic [31:0] alures;
    logic        alu0;
    logic [31:0] e_imm;
    logic [4:0]  e_alusel;
    logic [1:0]  e_bsel;
    logic [1:0]  e_osel;
    int          e_rdw;
    logic        e_mrd;
    logic        e_mwr;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    int          e_lat;
    logic        e_aen;
  } vec_t;

  vec_t vecs[16];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    bus.op             = v.op;
    bus.funct3         = v.f3;
    bus.funct7         = v.f7;
    bus.rs1            = v.rs1;
    bus.rs2            = v.rs2;
    bus.rd             = v.rd;
    bus.imm12          = v.imm12;
    bus.immhi          = v.immhi;
    bus.PCin           = v.pcin;
    bus.ALURes         = v.alures;
    bus.ALU0           = v.alu0;
    bus.dataReady      = 1'b1;
    bus.ALUcomplete    = 1'b1;
    bus.mem_ack        = 1'b1;
    bus.decodeComplete = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            name    op  f3 f7     rs1 rs2   rd   imm12    immhi     pcin      alures   a0 | imm          alusel bsel osel rdw mrd mwr addr      pc        lat aen
    vecs[0]  = '{"LB",    3,  0, 7'h00, 10, 0,    1,  12'h801, 20'h0,    32'h1,    32'h1234, 0, 32'hFFFFF801, 0,  1, 1, 1, 1, 0, 32'h1234, 32'h5,    5, 1};
    vecs[1]  = '{"SLTI",  19, 2, 7'h36, 3,  5'h13, 14, 12'h6D3, 20'h0,    32'h3,    32'h0,    0, 32'h000006D3, 3,  1, 0, 1, 0, 0, 32'h0,    32'h7,    4, 1};
    vecs[2]  = '{"XOR",   51, 4, 7'h00, 12, 19,   20, 12'h000, 20'h0,    32'h4,    32'h0,    0, 32'h0,        5,  0, 0, 1, 0, 0, 32'h0,    32'h8,    4, 1};
    vecs[3]  = '{"LUI",   55, 0, 7'h00, 0,  0,    12, 12'h000, 20'hB3535, 32'h0,   32'h0,    0, 32'hB3535000, 0,  0, 3, 1, 0, 0, 32'h0,    32'h4,    2, 0};
    vecs[4]  = '{"SH",    35, 1, 7'h58, 2,  5,    12, 12'hB0C, 20'h0,    32'h6,    32'hB0E,  0, 32'hFFFFFB0C, 0,  1, 0, 0, 0, 1, 32'hB0E,  32'hA,    5, 1};
    vecs[5]  = '{"SUB",   51, 0, 7'h20, 1,  2,    5,  12'h000, 20'h0,    32'h100,  32'h0,    0, 32'h0,        1,  0, 0, 1, 0, 0, 32'h0,    32'h104,  4, 1};
    vecs[6]  = '{"SRAI",  19, 5, 7'h20, 4,  5,    6,  12'h405, 20'h0,    32'h8,    32'h0,    0, 32'h5,        7,  1, 0, 1, 0, 0, 32'h0,    32'hC,    4, 1};
    vecs[7]  = '{"ADDI0", 19, 0, 7'h7F, 1,  5'h1F, 0, 12'hFFF, 20'h0,    32'h20,   32'h0,    0, 32'hFFFFFFFF, 0,  1, 0, 0, 0, 0, 32'h0,    32'h24,   4, 1};
    vecs[8]  = '{"BNE_T", 99, 1, 7'h00, 3,  4,    0,  12'h7F8, 20'h0,    32'h200,  32'h0,    1, 32'h00000FF0, 12, 0, 0, 0, 0, 0, 32'h0,    32'h11F0, 3, 1};
    vecs[9]  = '{"BGEU_N",99, 7, 7'h00, 3,  4,    0,  12'h800, 20'h0,    32'h40,   32'h0,    0, 32'hFFFFF000, 16, 0, 0, 0, 0, 0, 32'h0,    32'h44,   3, 1};
    vecs[10] = '{"BLT_T", 99, 4, 7'h00, 1,  2,    0,  12'hFFE, 20'h0,    32'h80,   32'h0,    1, 32'hFFFFFFFC, 13, 0, 0, 0, 0, 0, 32'h0,    32'h7C,   3, 1};
    vecs[11] = '{"BAD_OP",115,0, 7'h00, 1,  2,    3,  12'h123, 20'h0,    32'h10,   32'h0,    0, 32'h0,        0,  0, 0, 0, 0, 0, 32'h0,    32'h14,   1, 0};
    vecs[12] = '{"SLLI",  19, 1, 7'h00, 1,  5'h1F, 2, 12'h01F, 20'h0,    32'h0,    32'h0,    0, 32'h1F,       2,  1, 0, 1, 0, 0, 32'h0,    32'h4,    4, 1};
    vecs[13] = '{"SRL",   51, 5, 7'h00, 2,  3,    4,  12'h000, 20'h0,    32'h1000, 32'h0,    0, 32'h0,        6,  0, 0, 1, 0, 0, 32'h0,    32'h1004, 4, 1};
    vecs[14] = '{"BGE_N", 99, 5, 7'h00, 6,  7,    0,  12'h010, 20'h0,    32'h300,  32'h0,    0, 32'h20,       14, 0, 0, 0, 0, 0, 32'h0,    32'h304,  3, 1};
    vecs[15] = '{"AND",   51, 7, 7'h00, 8,  9,    10, 12'h000, 20'h0,    32'h50,   32'h0,    0, 32'h0,        9,  0, 0, 1, 0, 0, 32'h0,    32'h54,   4, 1};

    // ---------------- table-driven instructions through the scoreboard ----------------
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      vec_t e;
      int   lat;
      int   rdw;
      int   irn;
      logic mrd;
      logic mwr;
      logic aen;
      logic excl_bad;
      v = vecs[i];
      reset = 1'b1;
      apply(v);
      sb.push_back(v);
      tick();
      if (i == 0) begin
        chk("rst_reg_reset", {31'd0, bus.reg_reset}, 32'd1);
        chk("rst_pcout", bus.PCout, 32'd0);
        chk("rst_immvalue", bus.immvalue, 32'd0);
        chk("rst_strobes", {24'd0, bus.IRenable, bus.Aenable, bus.Benable, bus.rdWrite,
                            bus.reg_select, bus.mem_read, bus.mem_write, bus.execution_complete}, 32'd0);
      end
      reset = 1'b0;
      lat = -1; rdw = 0; irn = 0; mrd = 1'b0; mwr = 1'b0; aen = 1'b0; excl_bad = 1'b0;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
        tick();
        if (bus.rdWrite) rdw++;
        if (bus.IRenable) irn++;
        if (bus.mem_read) mrd = 1'b1;
        if (bus.mem_write) mwr = 1'b1;
        if (bus.Aenable) aen = 1'b1;
        if ((int'(bus.rdWrite) + int'(bus.mem_read) + int'(bus.mem_write)) > 1) excl_bad = 1'b1;
        if (bus.execution_complete) lat = c;
      end
      e = sb.pop_front();
      chk({e.name, "_latency"}, lat, e.e_lat);
      chk({e.name, "_immvalue"}, bus.immvalue, e.e_imm);
      chk({e.name, "_rs1Out"}, {27'd0, bus.rs1Out}, {27'd0, e.rs1});
      chk({e.name, "_rs2Out"}, {27'd0, bus.rs2Out}, {27'd0, e.rs2});
      chk({e.name, "_rdOut"}, {27'd0, bus.rdOut}, {27'd0, e.rd});
      chk({e.name, "_ALUsel"}, {27'd0, bus.ALUsel}, {27'd0, e.e_alusel});
      chk({e.name, "_Asel"}, {30'd0, bus.Asel}, 32'd0);
      chk({e.name, "_Bsel"}, {30'd0, bus.Bsel}, {30'd0, e.e_bsel});
      chk({e.name, "_Osel"}, {30'd0, bus.Osel}, {30'd0, e.e_osel});
      chk({e.name, "_rdWrite_cycles"}, rdw, e.e_rdw);
      chk({e.name, "_IRenable_cycles"}, irn, 32'd1);
      chk({e.name, "_mem_read_seen"}, {31'd0, mrd}, {31'd0, e.e_mrd});
      chk({e.name, "_mem_write_seen"}, {31'd0, mwr}, {31'd0, e.e_mwr});
      chk({e.name, "_read_phase"}, {31'd0, aen}, {31'd0, e.e_aen});
      chk({e.name, "_mem_address"}, bus.mem_address, e.e_addr);
      chk({e.name, "_PCout"}, bus.PCout, e.e_pc);
      chk({e.name, "_strobe_exclusive"}, {31'd0, excl_bad}, 32'd0);
      $display("txn %0d %s: PCin=0x%08h PCout=0x%08h imm=0x%08h cycles=%0d",
               i, e.name, e.pcin, bus.PCout, bus.immvalue, lat);
    end

    // hold DONE: outputs stay put and strobes stay low
    tick();
    tick();
    chk("done_hold_complete", {31'd0, bus.execution_complete}, 32'd1);
    chk("done_hold_pc", bus.PCout, 32'h54);
    chk("done_hold_rdwrite", {31'd0, bus.rdWrite}, 32'd0);

    // ---------------- load with stalled regfile, ALU and memory ----------------
    reset = 1'b1;
    apply(vecs[0]);
    bus.funct3 = 3'd2; bus.rs1 = 5'd7; bus.rd = 5'd9; bus.imm12 = 12'h010;
    bus.PCin = 32'h30; bus.ALURes = 32'h400;
    bus.dataReady = 1'b0; bus.ALUcomplete = 1'b0; bus.mem_ack = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("ldstall_aenable", {31'd0, bus.Aenable}, 32'd1);
    tick();
    chk("ldstall_aenable_hold", {30'd0, bus.Aenable, bus.Benable}, 32'd3);
    bus.dataReady = 1'b1;
    tick();
    chk("ldstall_aenable_drop", {31'd0, bus.Aenable}, 32'd0);
    bus.dataReady = 1'b0;
    tick();
    chk("ldstall_exec_wait", {31'd0, bus.mem_read}, 32'd0);
    bus.ALUcomplete = 1'b1;
    tick();
    chk("ldstall_mem_read", {31'd0, bus.mem_read}, 32'd1);
    chk("ldstall_mem_address", bus.mem_address, 32'h400);
    bus.ALUcomplete = 1'b0;
    tick();
    chk("ldstall_mem_read_hold", {31'd0, bus.mem_read}, 32'd1);
    chk("ldstall_no_wb_yet", {31'd0, bus.rdWrite}, 32'd0);
    bus.mem_ack = 1'b1;
    tick();
    chk("ldstall_mem_read_drop", {31'd0, bus.mem_read}, 32'd0);
    chk("ldstall_rdwrite", {30'd0, bus.rdWrite, bus.reg_select}, 32'd3);
    chk("ldstall_osel", {30'd0, bus.Osel}, 32'd1);
    bus.mem_ack = 1'b0;
    tick();
    chk("ldstall_rdwrite_drop", {31'd0, bus.rdWrite}, 32'd0);
    chk("ldstall_complete", {31'd0, bus.execution_complete}, 32'd1);
    chk("ldstall_pcout", bus.PCout, 32'h34);
    $display("txn seq LW stalled handshakes: PCout=0x%08h", bus.PCout);

    // ---------------- store waits for rs2 data, ack in entry cycle ----------------
    reset = 1'b1;
    apply(vecs[4]);
    bus.funct3 = 3'd2; bus.imm12 = 12'h004; bus.PCin = 32'h50; bus.ALURes = 32'h88;
    tick();
    reset = 1'b0;
    tick();
    tick();
    bus.dataReady = 1'b0;
    tick();
    chk("stwait_no_write", {31'd0, bus.mem_write}, 32'd0);
    chk("stwait_address", bus.mem_address, 32'h88);
    tick();
    chk("stwait_no_write_hold", {31'd0, bus.mem_write}, 32'd0);
    bus.dataReady = 1'b1;
    tick();
    chk("stwait_mem_write", {31'd0, bus.mem_write}, 32'd1);
    tick();
    chk("stwait_write_one_cycle", {31'd0, bus.mem_write}, 32'd0);
    chk("stwait_complete", {31'd0, bus.execution_complete}, 32'd1);
    chk("stwait_no_rdwrite", {31'd0, bus.rdWrite}, 32'd0);
    chk("stwait_pcout", bus.PCout, 32'h54);
    $display("txn seq SW data wait: PCout=0x%08h", bus.PCout);

    // ---------------- asynchronous reset during MEM ----------------
    reset = 1'b1;
    apply(vecs[0]);
    bus.mem_ack = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("rstmem_in_mem", {31'd0, bus.mem_read}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmem_mem_read_drop", {31'd0, bus.mem_read}, 32'd0);
    chk("rstmem_mem_write_low", {31'd0, bus.mem_write}, 32'd0);
    chk("rstmem_reg_reset", {31'd0, bus.reg_reset}, 32'd1);
    chk("rstmem_pcout", bus.PCout, 32'd0);
    bus.op = 7'd115;
    bus.PCin = 32'h60;
    tick();
    reset = 1'b0;
    tick();
    chk("rstmem_restart_decode", {31'd0, bus.execution_complete}, 32'd1);
    chk("rstmem_restart_pc", bus.PCout, 32'h64);
    chk("rstmem_reg_reset_drop", {31'd0, bus.reg_reset}, 32'd0);
    $display("txn seq reset in MEM: restart PCout=0x%08h", bus.PCout);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
